// File: rtl/dp_mem_pkg.sv
// Shared constants for the dual-port memory: clear-sequencer state encoding
// and the byte-lane width used by the write byte enables.
package dp_mem_pkg;

  localparam int BYTE_W = 8;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/dp_mem_clr_fsm.sv
// Post-reset clear sequencer: walks every word once, issuing a zero-write
// strobe per cycle, then parks in READY.
module dp_mem_clr_fsm
  import dp_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  init_busy_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o,
  output logic                  clr_we_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clrPtr_q, clrPtr_d;

  always_comb begin
    state_d  = state_q;
    clrPtr_d = clrPtr_q;
    if (state_q == ST_INIT) begin
      if (clrPtr_q == LAST_ADDR) begin
        state_d = ST_READY;
      end else begin
        clrPtr_d = clrPtr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_INIT;
      clrPtr_q <= '0;
    end else begin
      state_q  <= state_d;
      clrPtr_q <= clrPtr_d;
    end
  end

  assign init_busy_o = (state_q == ST_INIT);
  // The edge that samples rst restarts the sweep, so it must not count as a clear write.
  assign clr_we_o    = init_busy_o && !rst_i;
  assign clr_addr_o  = clrPtr_q;

endmodule

// File: rtl/dp_mem.sv
// Simple dual-port RAM with byte-enable writes, write-first same-address
// forwarding, optional read output register and a post-reset zeroing sweep.
module dp_mem
  import dp_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 16,
  parameter int MEM_WIDTH  = 16,
  parameter int RD_PIPE    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [MEM_WIDTH-1:0]        wr_data,
  input  logic [MEM_WIDTH/BYTE_W-1:0] wr_be,
  input  logic                        rd_en,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [MEM_WIDTH-1:0]        rd_data,
  output logic                        rd_valid,
  output logic                        init_busy,
  output logic                        addr_err
);

  localparam int                    NUM_BYTES = MEM_WIDTH / BYTE_W;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  if (MEM_DEPTH > (1 << ADDR_WIDTH)) begin : gDepthCheck
    $error("dp_mem: MEM_DEPTH does not fit in ADDR_WIDTH");
  end
  if ((MEM_WIDTH % BYTE_W) != 0) begin : gWidthCheck
    $error("dp_mem: MEM_WIDTH must be a whole number of bytes");
  end

  logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];
  logic                  clrWe;
  logic [ADDR_WIDTH-1:0] clrAddr;
  logic                  wrAcc, rdAcc, wrInRange, rdInRange;
  logic [MEM_WIDTH-1:0]  wrMask, rdWord, fwdWord;
  logic [MEM_WIDTH-1:0]  stageData_q;
  logic                  stageValid_q, addrErr_q;

  dp_mem_clr_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) uClrFsm (
    .clk_i       (clk),
    .rst_i       (rst),
    .init_busy_o (init_busy),
    .clr_addr_o  (clrAddr),
    .clr_we_o    (clrWe)
  );

  assign wrAcc     = wr_en && !init_busy && !rst;
  assign rdAcc     = rd_en && !init_busy && !rst;
  assign wrInRange = ({1'b0, wr_addr} < DEPTH_L);
  assign rdInRange = ({1'b0, rd_addr} < DEPTH_L);

  always_comb begin
    wrMask = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      wrMask[b*BYTE_W +: BYTE_W] = {BYTE_W{wr_be[b]}};
    end
  end

  always_ff @(posedge clk) begin
    if (clrWe) begin
      mem[clrAddr] <= '0;
    end else if (wrAcc && wrInRange) begin
      mem[wr_addr] <= (mem[wr_addr] & ~wrMask) | (wr_data & wrMask);
    end
  end

  // Same-address write in the same cycle is merged so reads see the new word.
  assign rdWord = mem[rdInRange ? rd_addr : '0];

  always_comb begin
    fwdWord = rdWord;
    if (wrAcc && wrInRange && (wr_addr == rd_addr)) begin
      fwdWord = (rdWord & ~wrMask) | (wr_data & wrMask);
    end
    if (!rdInRange) begin
      fwdWord = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stageValid_q <= 1'b0;
      stageData_q  <= '0;
      addrErr_q    <= 1'b0;
    end else begin
      stageValid_q <= rdAcc;
      if (rdAcc) begin
        stageData_q <= fwdWord;
      end
      addrErr_q <= (wrAcc && !wrInRange) || (rdAcc && !rdInRange);
    end
  end

  assign addr_err = addrErr_q;

  if (RD_PIPE != 0) begin : gOutReg
    logic [MEM_WIDTH-1:0] rdData_q;
    logic                 rdValid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdData_q  <= '0;
        rdValid_q <= 1'b0;
      end else begin
        rdValid_q <= stageValid_q;
        if (stageValid_q) begin
          rdData_q <= stageData_q;
        end
      end
    end

    assign rd_data  = rdData_q;
    assign rd_valid = rdValid_q;
  end else begin : gNoOutReg
    assign rd_data  = stageData_q;
    assign rd_valid = stageValid_q;
  end

endmodule

// File: tb/tb_dp_mem.sv
// Scoreboard bench driving two dp_mem instances with shared stimulus:
// a default 16-word 1-cycle memory and a 12-word memory with the output register.
module tb_dp_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEn, rdEn;
  logic [3:0]  wrAddr, rdAddr;
  logic [15:0] wrData;
  logic [1:0]  wrBe;
  logic [15:0] rdData0, rdData1;
  logic        rdValid0, rdValid1, initBusy0, initBusy1, addrErr0, addrErr1;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_exp_t;

  rd_exp_t     rdQ0[$], rdQ1[$];
  int          errQ0[$], errQ1[$];
  logic [15:0] mdl [2][16];
  int          busyCnt [2];
  logic [15:0] lastData [2];
  int          cyc = 0;
  bit          started = 1'b0;
  int          checks = 0;
  int          passes = 0;

  dp_mem uDut0 (
    .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .wr_be(wrBe), .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData0),
    .rd_valid(rdValid0), .init_busy(initBusy0), .addr_err(addrErr0)
  );

  dp_mem #(.ADDR_WIDTH(4), .MEM_DEPTH(12), .MEM_WIDTH(16), .RD_PIPE(1)) uDut1 (
    .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .wr_be(wrBe), .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData1),
    .rd_valid(rdValid1), .init_busy(initBusy1), .addr_err(addrErr1)
  );

  always #5 clk = ~clk;

  function automatic int depthOf(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic int pipeOf(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reset discards everything that would have surfaced from this edge onward.
  task automatic dropPending(input int k);
    if (k == 0) begin
      while (rdQ0.size() > 0 && rdQ0[rdQ0.size()-1].due >= cyc) rdQ0.delete(rdQ0.size()-1);
      while (errQ0.size() > 0 && errQ0[errQ0.size()-1] >= cyc) errQ0.delete(errQ0.size()-1);
    end else begin
      while (rdQ1.size() > 0 && rdQ1[rdQ1.size()-1].due >= cyc) rdQ1.delete(rdQ1.size()-1);
      while (errQ1.size() > 0 && errQ1[errQ1.size()-1] >= cyc) errQ1.delete(errQ1.size()-1);
    end
  endtask

  task automatic modelStep(input int k);
    logic [15:0] mask, word;
    bit          wrIn, rdIn;
    rd_exp_t     e;
    if (rst) begin
      busyCnt[k]  = depthOf(k);
      lastData[k] = 16'h0;
      for (int a = 0; a < 16; a++) mdl[k][a] = 16'h0;
      dropPending(k);
    end else if (busyCnt[k] > 0) begin
      busyCnt[k]--;
    end else begin
      mask = {{8{wrBe[1]}}, {8{wrBe[0]}}};
      wrIn = int'(wrAddr) < depthOf(k);
      rdIn = int'(rdAddr) < depthOf(k);
      if (wrEn && wrIn) mdl[k][wrAddr] = (mdl[k][wrAddr] & ~mask) | (wrData & mask);
      if (rdEn) begin
        word   = rdIn ? mdl[k][rdAddr] : 16'h0;
        e.due  = cyc + pipeOf(k);
        e.data = word;
        if (k == 0) rdQ0.push_back(e); else rdQ1.push_back(e);
      end
      if ((wrEn && !wrIn) || (rdEn && !rdIn)) begin
        if (k == 0) errQ0.push_back(cyc); else errQ1.push_back(cyc);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) started = 1'b1;
    if (started) begin
      modelStep(0);
      modelStep(1);
    end
  end

  task automatic monitorInst(input int k, input logic v, input logic [15:0] d,
                             input logic busy, input logic err);
    bit          expV, expE;
    logic [15:0] expD;
    rd_exp_t     e;
    expV = 1'b0;
    expE = 1'b0;
    expD = lastData[k];
    if (k == 0) begin
      if (rdQ0.size() > 0 && rdQ0[0].due == cyc) begin e = rdQ0.pop_front(); expV = 1'b1; expD = e.data; end
      if (errQ0.size() > 0 && errQ0[0] == cyc) begin void'(errQ0.pop_front()); expE = 1'b1; end
    end else begin
      if (rdQ1.size() > 0 && rdQ1[0].due == cyc) begin e = rdQ1.pop_front(); expV = 1'b1; expD = e.data; end
      if (errQ1.size() > 0 && errQ1[0] == cyc) begin void'(errQ1.pop_front()); expE = 1'b1; end
    end
    checkOutput($sformatf("initBusy%0d", k), 32'(busy), 32'(busyCnt[k] > 0));
    checkOutput($sformatf("rdValid%0d", k), 32'(v), 32'(expV));
    checkOutput($sformatf("rdData%0d", k), 32'(d), 32'(expD));
    checkOutput($sformatf("addrErr%0d", k), 32'(err), 32'(expE));
    lastData[k] = expD;
  endtask

  always @(negedge clk) begin
    if (started) begin
      monitorInst(0, rdValid0, rdData0, initBusy0, addrErr0);
      monitorInst(1, rdValid1, rdData1, initBusy1, addrErr1);
    end
  end

  task automatic applyStimulus(input bit we, input logic [3:0] wa, input logic [15:0] wd,
                               input logic [1:0] be, input bit re, input logic [3:0] ra);
    wrEn   = we;
    wrAddr = wa;
    wrData = wd;
    wrBe   = be;
    rdEn   = re;
    rdAddr = ra;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0);
  endtask

  task automatic readAll();
    for (int a = 0; a < 16; a++) applyStimulus(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'(a));
  endtask

  initial begin
    rst = 1'b1;
    wrEn = 1'b0; wrAddr = '0; wrData = '0; wrBe = '0; rdEn = 1'b0; rdAddr = '0;
    busyCnt[0] = 0; busyCnt[1] = 0;
    lastData[0] = '0; lastData[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(18);
    readAll();

    applyStimulus(1'b1, 4'd3, 16'hA5C3, 2'b11, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'd3, 16'h1177, 2'b01, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd3);
    applyStimulus(1'b1, 4'd5, 16'hBEEF, 2'b11, 1'b1, 4'd5);
    applyStimulus(1'b1, 4'd13, 16'h1234, 2'b11, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd13);
    idle(2);
    readAll();

    for (int a = 0; a < 16; a++)
      applyStimulus(1'b1, 4'(a), 16'(16'h1111 * a + 16'h0F0F), 2'($urandom_range(1, 3)), 1'b0, 4'd0);
    readAll();

    // Restart the sweep mid-way while writes are requested throughout.
    rst = 1'b1;
    applyStimulus(1'b1, 4'd2, 16'hFFFF, 2'b11, 1'b0, 4'd0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 4'(i), 16'hFFFF, 2'b11, 1'b0, 4'd0);
    rst = 1'b1;
    applyStimulus(1'b1, 4'd7, 16'hFFFF, 2'b11, 1'b0, 4'd0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 4'd2, 16'hDEAD, 2'b11, 1'b0, 4'd0);
    idle(3);
    readAll();

    // Reset in READY with reads still in flight.
    applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd4);
    rst = 1'b0;
    idle(18);

    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom),
                    1'($urandom), 4'($urandom));
    idle(4);

    checkOutput("rdQueue0Empty", 32'(rdQ0.size()), 32'd0);
    checkOutput("rdQueue1Empty", 32'(rdQ1.size()), 32'd0);
    checkOutput("errQueue0Empty", 32'(errQ0.size()), 32'd0);
    checkOutput("errQueue1Empty", 32'(errQ1.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dp_mem.md
DP_MEM -- requirements
Module: dp_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: width of both address ports.
REQ-002 Parameter MEM_DEPTH, default 16: number of words; the block SHALL require MEM_DEPTH <= 2**ADDR_WIDTH.
REQ-003 Parameter MEM_WIDTH, default 16: word width in bits; the block SHALL require MEM_WIDTH to be a multiple of 8.
REQ-004 Parameter RD_PIPE, default 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_addr  input  ADDR_WIDTH  write address.
REQ-009 wr_data  input  MEM_WIDTH  write data.
REQ-010 wr_be  input  MEM_WIDTH/8  byte enables; bit i qualifies wr_data[8i+7:8i].
REQ-011 rd_en  input  1  read request.
REQ-012 rd_addr  input  ADDR_WIDTH  read address.
REQ-013 rd_data  output  MEM_WIDTH  read data.
REQ-014 rd_valid  output  1  one-cycle pulse marking rd_data valid.
REQ-015 init_busy  output  1  high while the post-reset clear sweep runs.
REQ-016 addr_err  output  1  one-cycle pulse on an accepted access to an address >= MEM_DEPTH.

Function
REQ-017 Clear FSM states SHALL be INIT and READY; rst forces INIT with clear pointer 0.
REQ-018 In INIT, the block SHALL write all-zeros to word clear_ptr each cycle, then increment; after writing MEM_DEPTH-1 it SHALL go to READY. init_busy is 1 in INIT and 0 in READY, giving exactly MEM_DEPTH busy cycles.
REQ-019 wr_en and rd_en SHALL be ignored while init_busy=1: no write, no rd_valid, no addr_err.
REQ-020 In READY, when wr_en=1 and wr_addr < MEM_DEPTH, the block SHALL update only the bytes with wr_be=1 at the clock edge; other bytes are unchanged.
REQ-021 In READY, when rd_en=1 and rd_addr < MEM_DEPTH, the word SHALL appear on rd_data with rd_valid=1 one cycle later (RD_PIPE=0) or two cycles later (RD_PIPE=1).
REQ-022 Reads and writes are independent; both may be accepted in the same cycle.
REQ-023 Same-cycle read and write to one address: the read returns the new word (write-first), with byte enables applied.
REQ-024 An out-of-range write SHALL be discarded and pulse addr_err the next cycle.
REQ-025 An out-of-range read SHALL return rd_data=0 with rd_valid=1 at normal latency and pulse addr_err the next cycle.
REQ-026 When no read completes, rd_data SHALL hold its last value and rd_valid SHALL be 0.
REQ-027 Back-to-back reads on consecutive cycles SHALL produce consecutive rd_valid pulses at full throughput in both RD_PIPE modes.

Reset
REQ-028 On rst=1 the block SHALL set rd_data=0, rd_valid=0, addr_err=0 and init_busy=1 (from the next cycle); pipeline stages are flushed.
REQ-029 rst during INIT restarts the sweep at address 0. rst during READY discards in-flight reads with no rd_valid, and re-clears all memory.
REQ-030 Memory array contents are not reset directly; zeroing is done only by the INIT sweep.

Structure
REQ-031 Shared package dp_mem_pkg SHALL hold the FSM state encoding (INIT, READY) and the byte-lane width constant 8.
REQ-032 The clear FSM and pointer SHALL be a sub-module, dp_mem_clr_fsm, that outputs init_busy, clear address and clear write strobe.
REQ-033 The storage array and read pipeline stay in dp_mem.

Verification
REQ-034 Pulse rst for 1 cycle, then release -> init_busy=1 for exactly 16 cycles; any read afterwards returns 0x0000.
REQ-035 Write 0xA5C3 to addr 3 with be=2'b11, then with be=2'b01 write 0x1177 -> a read of addr 3 returns 0xA577 with rd_valid 1 cycle later (RD_PIPE=0) or 2 cycles later (RD_PIPE=1).
REQ-036 Same cycle: write 0xBEEF to addr 5 and read addr 5 -> rd_data=0xBEEF.
REQ-037 With MEM_DEPTH=12, write addr 13 and then read addr 13 -> addr_err pulses twice, rd_data=0x0000, and no word in the array changes.
REQ-038 Assert rst on sweep cycle 7, hold wr_en=1 during INIT -> sweep restarts at 0, write is ignored, init_busy lasts 16 cycles after release.
REQ-039 Issue reads to addrs 0..15 on consecutive cycles -> 16 consecutive rd_valid pulses with data in order.
